// File: rtl/led7seg_pkg.sv
// Shared defaults and word-field helpers for the 74HC595 LED7seg serial link.
// A word is packed as {seg, dig} with the digit-select field in the low bits.
package led7seg_pkg;

    localparam int unsigned DEF_DIG_NUM   = 8;
    localparam int unsigned DEF_SEG_NUM   = 8;
    localparam int unsigned DEF_CHA_WIDTH = DEF_DIG_NUM + DEF_SEG_NUM;
    localparam int unsigned DEF_DAT_WIDTH = DEF_DIG_NUM * DEF_SEG_NUM;

    typedef logic [DEF_CHA_WIDTH-1:0] word_t;

    typedef struct packed {
        logic       ok;
        logic [4:0] idx;
    } onehot_t;

    function automatic logic [DEF_SEG_NUM-1:0] seg_of(input word_t w);
        return w[DEF_CHA_WIDTH-1 -: DEF_SEG_NUM];
    endfunction

    function automatic logic [DEF_DIG_NUM-1:0] dig_of(input word_t w);
        return w[DEF_DIG_NUM-1:0];
    endfunction

    // Callers zero-extend narrower digit fields, so up to 32 digits are covered.
    function automatic onehot_t onehot_idx(input logic [31:0] v);
        onehot_t     r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) begin
                n++;
                r.idx = 5'(i);
            end
        end
        r.ok = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, with a rising-edge pulse
// and a one-cycle-delayed copy of the synchronized level.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic dly_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~dly_q;
    assign dly_o  = dly_q;

endmodule

// File: rtl/led7seg_74hc595_receiver.sv
// Receive end of the 74HC595 LED7seg link: rebuilds {seg,dig} words from
// sclk/rclk/dio and reassembles them into a full multi-digit frame.
module led7seg_74hc595_receiver
    import led7seg_pkg::*;
#(
    parameter int unsigned DIG_NUM   = DEF_DIG_NUM,
    parameter int unsigned SEG_NUM   = DEF_SEG_NUM,
    parameter logic        DIG_POL   = 1'b1,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned CHA_WIDTH = DIG_NUM + SEG_NUM,
    parameter int unsigned DAT_WIDTH = DIG_NUM * SEG_NUM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 rclk,
    input  logic                 dio,
    output logic [CHA_WIDTH-1:0] word,
    output logic                 word_vld,
    output logic [DAT_WIDTH-1:0] dat,
    output logic                 vld,
    output logic                 len_err,
    output logic                 sel_err
);

    localparam int unsigned CNT_W  = $clog2(CHA_WIDTH + 2);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic sclk_sync, sclk_rise, sclk_dly;
    logic rclk_sync, rclk_rise, rclk_dly;
    logic dio_sync, dio_rise, dio_dly;
    logic sync_unused;

    sync_edge_det u_sync_sclk (
        .clk(clk), .rst(rst), .din_i(sclk),
        .sync_o(sclk_sync), .rise_o(sclk_rise), .dly_o(sclk_dly)
    );
    sync_edge_det u_sync_rclk (
        .clk(clk), .rst(rst), .din_i(rclk),
        .sync_o(rclk_sync), .rise_o(rclk_rise), .dly_o(rclk_dly)
    );
    sync_edge_det u_sync_dio (
        .clk(clk), .rst(rst), .din_i(dio),
        .sync_o(dio_sync), .rise_o(dio_rise), .dly_o(dio_dly)
    );

    assign sync_unused = ^{sclk_sync, sclk_dly, rclk_sync, rclk_dly, dio_rise, dio_dly};

    // Stage 1: shift register, bit counter, idle timeout, word candidate capture
    logic [CHA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [CHA_WIDTH-1:0] cand_q, cand_d;
    logic                 cand_vld_q, cand_vld_d;
    logic                 len_err_q, len_err_d;

    // Stage 2: digit decode, frame assembly, output registers
    logic [CHA_WIDTH-1:0] word_q, word_d;
    logic                 word_vld_q, word_vld_d;
    logic [DAT_WIDTH-1:0] buf_q, buf_d;
    logic [DIG_NUM-1:0]   seen_q, seen_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic                 vld_q, vld_d;
    logic                 sel_err_q, sel_err_d;

    logic [DIG_NUM-1:0]   dig_c;
    logic [SEG_NUM-1:0]   seg_c;
    onehot_t              oh;

    always_comb begin
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        idle_d     = idle_q;
        cand_d     = cand_q;
        cand_vld_d = 1'b0;
        len_err_d  = 1'b0;

        if (bitcnt_q != '0 && idle_q != IDLE_W'(TIMEOUT)) begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_W'(TIMEOUT)) begin
                bitcnt_d = '0;
            end
        end

        if (sclk_rise) begin
            shreg_d  = {shreg_q[CHA_WIDTH-2:0], dio_sync};
            bitcnt_d = (bitcnt_q == CNT_W'(CHA_WIDTH + 1)) ? bitcnt_q : bitcnt_q + 1'b1;
            idle_d   = '0;
        end

        // A coincident sclk bit is not part of this word; it opens the next one.
        if (rclk_rise) begin
            cand_d     = shreg_q;
            cand_vld_d = (bitcnt_q == CNT_W'(CHA_WIDTH));
            len_err_d  = (bitcnt_q != CNT_W'(CHA_WIDTH));
            bitcnt_d   = sclk_rise ? CNT_W'(1) : '0;
        end
    end

    always_comb begin
        dig_c      = cand_q[DIG_NUM-1:0] ^ {DIG_NUM{~DIG_POL}};
        seg_c      = cand_q[CHA_WIDTH-1 -: SEG_NUM];
        oh         = onehot_idx(32'(dig_c));
        word_d     = word_q;
        word_vld_d = 1'b0;
        buf_d      = buf_q;
        seen_d     = seen_q;
        dat_d      = dat_q;
        vld_d      = 1'b0;
        sel_err_d  = 1'b0;

        if (cand_vld_q) begin
            if (oh.ok) begin
                word_d     = cand_q;
                word_vld_d = 1'b1;
                for (int unsigned i = 0; i < DIG_NUM; i++) begin
                    if (oh.idx == 5'(i)) begin
                        buf_d[i*SEG_NUM +: SEG_NUM] = seg_c;
                        seen_d[i]                   = 1'b1;
                    end
                end
                if (&seen_d) begin
                    dat_d  = buf_d;
                    vld_d  = 1'b1;
                    seen_d = '0;
                end
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            idle_q     <= '0;
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
            len_err_q  <= 1'b0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            buf_q      <= '0;
            seen_q     <= '0;
            dat_q      <= '0;
            vld_q      <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            idle_q     <= idle_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            len_err_q  <= len_err_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            buf_q      <= buf_d;
            seen_q     <= seen_d;
            dat_q      <= dat_d;
            vld_q      <= vld_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign word     = word_q;
    assign word_vld = word_vld_q;
    assign dat      = dat_q;
    assign vld      = vld_q;
    assign len_err  = len_err_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_led7seg_74hc595_receiver.sv
// Scoreboard bench: a serial-link driver feeds the receiver and a reference
// model queues expected events that an independent monitor pops and compares.
module tb_led7seg_74hc595_receiver;
    import led7seg_pkg::*;

    localparam int unsigned TO = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        rclk = 1'b0;
    logic        dio = 1'b0;
    logic [15:0] word;
    logic        word_vld;
    logic [63:0] dat;
    logic        vld;
    logic        len_err;
    logic        sel_err;

    always #5 clk = ~clk;

    led7seg_74hc595_receiver #(
        .DIG_NUM(8), .SEG_NUM(8), .DIG_POL(1'b1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio),
        .word(word), .word_vld(word_vld), .dat(dat), .vld(vld),
        .len_err(len_err), .sel_err(sel_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_word_q[$];
    logic [63:0] exp_frame_q[$];
    logic [15:0] exp_len_q[$];
    logic [15:0] exp_sel_q[$];

    // Reference model: what the link has delivered, in terms of whole words/digits
    logic [7:0]  m_slot[8];
    bit          m_seen[8];
    logic [15:0] m_word;
    logic [15:0] m_last16;
    int          m_bits;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_slot[i] = 8'h00;
            m_seen[i] = 1'b0;
        end
        m_word   = 16'h0000;
        m_last16 = 16'h0000;
        m_bits   = 0;
    endtask

    task automatic model_latch();
        logic [7:0]  d;
        logic [63:0] f;
        int          idx;
        bit          all;
        if (m_bits != 16) begin
            exp_len_q.push_back(m_word);
        end else begin
            d = dig_of(m_last16);
            if ($countones(d) == 1) begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (d == 8'(1 << i)) idx = i;
                m_slot[idx] = seg_of(m_last16);
                m_seen[idx] = 1'b1;
                m_word      = m_last16;
                exp_word_q.push_back(m_word);
                all = 1'b1;
                for (int i = 0; i < 8; i++) all = all & m_seen[i];
                if (all) begin
                    for (int i = 0; i < 8; i++) begin
                        f[i*8 +: 8] = m_slot[i];
                        m_seen[i]   = 1'b0;
                    end
                    exp_frame_q.push_back(f);
                end
            end else begin
                exp_sel_q.push_back(m_word);
            end
        end
        m_bits = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sclk = 1'b0;
        dio  = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        m_last16 = {m_last16[14:0], b};
        if (m_bits < 17) m_bits++;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_rclk();
        sclk = 1'b0;
        tick(4);
        rclk = 1'b1;
        model_latch();
        tick(4);
        rclk = 1'b0;
        tick(4);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_bits(32'(w), 16);
        send_rclk();
    endtask

    task automatic idle(input int n);
        sclk = 1'b0;
        tick(n);
        if (n > TO) m_bits = 0;
    endtask

    // Monitor: pops an expectation for every pulse the receiver presents
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (word_vld) begin
                    if (exp_word_q.size() == 0) check("word_vld_unexpected", 64'(word_vld), 64'd0);
                    else check("word", 64'(word), 64'(exp_word_q.pop_front()));
                end
                if (vld) begin
                    if (exp_frame_q.size() == 0) check("vld_unexpected", 64'(vld), 64'd0);
                    else check("dat", dat, exp_frame_q.pop_front());
                end
                if (len_err) begin
                    if (exp_len_q.size() == 0) check("len_err_unexpected", 64'(len_err), 64'd0);
                    else check("len_err_word_kept", 64'(word), 64'(exp_len_q.pop_front()));
                end
                if (sel_err) begin
                    if (exp_sel_q.size() == 0) check("sel_err_unexpected", 64'(sel_err), 64'd0);
                    else check("sel_err_word_kept", 64'(word), 64'(exp_sel_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] frame;
        logic [7:0]  seg;
        logic [7:0]  dg;
        int          r;
        int          k;

        model_reset();
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_word", 64'(word), 64'd0);
        check("rst_word_vld", 64'(word_vld), 64'd0);
        check("rst_dat", dat, 64'd0);
        check("rst_vld", 64'(vld), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_sel_err", 64'(sel_err), 64'd0);

        // Single word into slot 0
        send_word(16'hC001);
        tick(10);
        check("t1_word", 64'(word), 64'hC001);

        // Full frame of eight digits
        for (int i = 0; i < 8; i++) send_word({8'(8'h10 + i), 8'(1 << i)});
        tick(10);
        check("t2_dat", dat, 64'h17161514_13121110);

        // Short word, then a normal one
        send_bits(32'h0000_7ABC, 15);
        send_rclk();
        send_word(16'h5508);

        // Multi-hot and empty digit selects
        send_word(16'hFF03);
        send_word(16'hFF00);

        // Partial word abandoned by idle timeout
        send_bits(32'h0000_00A5, 8);
        idle(TO + 10);
        send_word(16'h3C20);
        tick(10);
        check("t5_word", 64'(word), 64'h3C20);

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) send_word({8'(8'h60 + i), 8'(1 << i)});
        tick(10);
        rst = 1'b1;
        tick(3);
        check("t6_rst_word", 64'(word), 64'd0);
        check("t6_rst_dat", dat, 64'd0);
        model_reset();
        rst = 1'b0;
        tick(3);
        for (int i = 7; i >= 0; i--) send_word({8'(8'hA0 + i), 8'(1 << i)});
        tick(10);
        check("t6_dat", dat, 64'hA7A6A5A4_A3A2A1A0);

        // Randomised mix of good, bad-select and bad-length words
        for (int n = 0; n < 60; n++) begin
            r   = $urandom_range(0, 99);
            seg = 8'($urandom);
            k   = $urandom_range(0, 7);
            if (r < 75) begin
                send_word({seg, 8'(1 << k)});
            end else if (r < 87) begin
                dg = (r % 2 == 1) ? 8'h00
                   : 8'(1 << k) | 8'(1 << ((k + 1 + $urandom_range(0, 6)) % 8));
                send_word({seg, dg});
            end else begin
                send_bits($urandom, $urandom_range(0, 1) == 1 ? $urandom_range(10, 15)
                                                              : $urandom_range(17, 20));
                send_rclk();
            end
        end

        // Controller-style loopback: each random frame refreshed twice
        for (int f = 0; f < 3; f++) begin
            frame = {$urandom, $urandom};
            for (int rep = 0; rep < 2; rep++)
                for (int i = 0; i < 8; i++) send_word({frame[i*8 +: 8], 8'(1 << i)});
            tick(10);
            check("loopback_dat", dat, frame);
        end

        tick(20);
        check("pending_word", 64'(exp_word_q.size()), 64'd0);
        check("pending_frame", 64'(exp_frame_q.size()), 64'd0);
        check("pending_len_err", 64'(exp_len_q.size()), 64'd0);
        check("pending_sel_err", 64'(exp_sel_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
